mux_rr_stream: RTL and testbench

- Parametrised successor to the 4:1 32-bit select mux. Selects one of CH valid/ready input streams onto one registered output stream.
- Two modes: fixed select (the classic mux behaviour) and fair round-robin arbitration.
- Sits between datapath producers, such as ALU/memory/immediate result sources, and a single downstream consumer that may stall.

---
 rtl/mux_rr_pkg.sv | 25 ++
 rtl/rr_arbiter_n.sv | 32 +++
 rtl/mux_rr_stream.sv | 82 ++++++++
 tb/tb_mux_rr_stream.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/mux_rr_pkg.sv
// Shared constants, output-register state type and helpers for the
// round-robin / fixed-select stream mux.
package mux_rr_pkg;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    // Widest one-hot vector the index helper accepts.
    localparam int MAX_CH = 64;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } out_state_t;

    function automatic int unsigned onehot_to_idx(input logic [MAX_CH-1:0] oh);
        int unsigned idx;
        idx = 0;
        for (int i = 0; i < MAX_CH; i++) begin
            if (oh[i]) idx = i;
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_arbiter_n.sv
// Combinational round-robin arbiter: grants the first requester at or
// above ptr, wrapping from CH-1 back to 0.
module rr_arbiter_n
    import mux_rr_pkg::*;
#(
    parameter  int CH   = 4,
    localparam int SELW = $clog2(CH)
) (
    input  logic [CH-1:0]   req,
    input  logic [SELW-1:0] ptr,
    input  logic            en,
    output logic [CH-1:0]   gnt,
    output logic [SELW-1:0] gnt_idx
);

    logic [SELW-1:0] idx;

    // Scan from farthest to nearest so the nearest requester is written last.
    always_comb begin
        gnt = '0;
        idx = '0;
        for (int k = CH - 1; k >= 0; k--) begin
            idx = SELW'((int'(ptr) + k) % CH);
            if (en && req[idx]) begin
                gnt      = '0;
                gnt[idx] = 1'b1;
            end
        end
        gnt_idx = SELW'(onehot_to_idx(MAX_CH'(gnt)));
    end

endmodule

// File: rtl/mux_rr_stream.sv
// CH-way valid/ready stream mux with fixed-select or round-robin mode
// feeding a single registered, stallable output slot.
module mux_rr_stream
    import mux_rr_pkg::*;
#(
    parameter  int WIDTH = 32,
    parameter  int CH    = 4,
    localparam int SELW  = $clog2(CH)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                mode,
    input  logic [SELW-1:0]     sel,
    input  logic [CH-1:0]       in_valid,
    input  logic [CH*WIDTH-1:0] in_data,
    output logic [CH-1:0]       in_ready,
    output logic                out_valid,
    output logic [WIDTH-1:0]    out_data,
    output logic [SELW-1:0]     out_ch,
    input  logic                out_ready
);

    // Handshake: a beat moves on any port only in a cycle where both valid
    // and ready are high at the rising edge; ready never waits on the
    // same-port valid being low, and producers keep valid up until accepted.

    out_state_t      state, state_next;
    logic [SELW-1:0] ptr;
    logic [CH-1:0]   rr_gnt, fix_gnt, grant, xfer_vec;
    logic [SELW-1:0] rr_idx, gnt_idx;
    logic            can_load, xfer;

    rr_arbiter_n #(.CH(CH)) u_arb (
        .req     (in_valid),
        .ptr     (ptr),
        .en      (mode == MODE_RR),
        .gnt     (rr_gnt),
        .gnt_idx (rr_idx)
    );

    // Out-of-range sel (non power-of-two CH) yields no grant.
    always_comb begin
        fix_gnt = '0;
        if (mode == MODE_FIXED && int'(sel) < CH) begin
            if (in_valid[sel]) fix_gnt[sel] = 1'b1;
        end
    end

    assign grant     = (mode == MODE_RR) ? rr_gnt : fix_gnt;
    assign gnt_idx   = (mode == MODE_RR) ? rr_idx : sel;
    assign can_load  = (state == ST_EMPTY) || out_ready;
    assign in_ready  = grant & {CH{can_load & rst_n}};
    assign xfer_vec  = in_valid & in_ready;
    assign xfer      = |xfer_vec;
    assign out_valid = (state == ST_FULL);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_EMPTY;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (can_load) state_next = xfer ? ST_FULL : ST_EMPTY;
    end

    // Data, channel tag and rr pointer only move on an accepted beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data <= '0;
            out_ch   <= '0;
            ptr      <= '0;
        end else if (xfer) begin
            out_data <= in_data[gnt_idx*WIDTH +: WIDTH];
            out_ch   <= gnt_idx;
            if (mode == MODE_RR) begin
                ptr <= (int'(gnt_idx) == CH - 1) ? '0 : gnt_idx + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mux_rr_stream.sv
// Scoreboard bench for mux_rr_stream: a reference model predicts grants,
// ready, pointer and output beats; a CH=3 instance covers out-of-range sel.
module tb_mux_rr_stream;

    localparam int WIDTH = 32;
    localparam int CH    = 4;
    localparam int SELW  = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic                mode, out_ready, out_valid;
    logic [SELW-1:0]     sel, out_ch;
    logic [CH-1:0]       in_valid, in_ready;
    logic [CH*WIDTH-1:0] in_data;
    logic [WIDTH-1:0]    out_data;

    logic          mode3, out_ready3, out_valid3;
    logic [1:0]    sel3, out_ch3;
    logic [2:0]    in_valid3, in_ready3;
    logic [95:0]   in_data3;
    logic [31:0]   out_data3;

    mux_rr_stream #(.WIDTH(WIDTH), .CH(CH)) u_dut (
        .clk(clk), .rst_n(rst_n), .mode(mode), .sel(sel),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_ch(out_ch),
        .out_ready(out_ready)
    );

    mux_rr_stream #(.WIDTH(32), .CH(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .mode(mode3), .sel(sel3),
        .in_valid(in_valid3), .in_data(in_data3), .in_ready(in_ready3),
        .out_valid(out_valid3), .out_data(out_data3), .out_ch(out_ch3),
        .out_ready(out_ready3)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model state and scoreboard
    logic [SELW+WIDTH-1:0] exp_q[$];
    logic m_full = 1'b0;
    int   m_ptr  = 0;
    logic mon_en = 1'b0;

    function automatic int model_grant();
        if (mode == 1'b0) begin
            if (int'(sel) < CH && in_valid[sel]) return int'(sel);
            return -1;
        end
        for (int k = 0; k < CH; k++) begin
            if (in_valid[(m_ptr + k) % CH]) return (m_ptr + k) % CH;
        end
        return -1;
    endfunction

    always @(negedge clk) begin
        int g;
        logic can;
        logic [CH-1:0] er;
        logic [SELW+WIDTH-1:0] item;
        if (mon_en) begin
            can = !m_full || out_ready;
            g   = model_grant();
            er  = '0;
            if (g >= 0 && can) er[g] = 1'b1;
            check("in_ready", 64'(in_ready), 64'(er));
            check("out_valid", 64'(out_valid), 64'(m_full));
            check("ptr", 64'(u_dut.ptr), 64'(m_ptr));
            if (m_full) begin
                if (exp_q.size() == 0) begin
                    check("queue_underflow", 64'(exp_q.size()), 64'd1);
                end else begin
                    item = exp_q[0];
                    check("out_beat", 64'({out_ch, out_data}), 64'(item));
                    if (out_ready) void'(exp_q.pop_front());
                end
            end
            if (can) begin
                if (g >= 0) begin
                    exp_q.push_back({SELW'(g), in_data[g*WIDTH +: WIDTH]});
                    m_full = 1'b1;
                    if (mode) m_ptr = (g + 1) % CH;
                end else begin
                    m_full = 1'b0;
                end
            end
        end
    end

    // Driver tasks
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic m, input logic [SELW-1:0] s,
                         input logic [CH-1:0] v, input logic r);
        mode = m; sel = s; in_valid = v; out_ready = r;
    endtask

    task automatic set_data_fixed();
        for (int i = 0; i < CH; i++) in_data[i*WIDTH +: WIDTH] = 32'hA0 + i;
    endtask

    task automatic model_reset();
        m_full = 1'b0;
        m_ptr  = 0;
        exp_q.delete();
    endtask

    initial begin
        drive(1'b0, '0, '1, 1'b1);
        set_data_fixed();
        mode3 = 1'b0; sel3 = 2'd0; in_valid3 = '0; out_ready3 = 1'b1;
        for (int i = 0; i < 3; i++) in_data3[i*32 +: 32] = 32'hB0 + i;

        // Reset state
        #12;
        check("rst_in_ready", 64'(in_ready), 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_data", 64'(out_data), 64'd0);
        check("rst_out_ch", 64'(out_ch), 64'd0);
        in_valid = '0;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        tick(1);
        mon_en = 1'b1;

        // Fixed select, sel=2
        drive(1'b0, 2'd2, 4'hF, 1'b1);
        tick(6);
        check("fixed_data", 64'(out_data), 64'h0000_00A2);
        check("fixed_ch", 64'(out_ch), 64'd2);

        // Round-robin fairness
        drive(1'b1, 2'd0, 4'hF, 1'b1);
        tick(9);

        // Move ptr to 3, then sparse ch1/ch3 with wrap
        drive(1'b1, 2'd0, 4'b0100, 1'b1);
        tick(1);
        drive(1'b1, 2'd0, 4'b1010, 1'b1);
        tick(4);

        // Backpressure for 3 cycles then drain+load together
        drive(1'b1, 2'd0, 4'b0001, 1'b0);
        tick(3);
        out_ready = 1'b1;
        tick(2);

        // Idle
        drive(1'b1, 2'd0, 4'b0000, 1'b1);
        tick(3);

        // CH=3 instance: sel=3 is out of range
        in_valid3 = 3'b111; sel3 = 2'd3;
        tick(2);
        check("sel_oor_ready", 64'(in_ready3), 64'd0);
        check("sel_oor_valid", 64'(out_valid3), 64'd0);
        sel3 = 2'd2;
        #1;
        check("sel2_ready", 64'(in_ready3), 64'b100);
        tick(1);
        check("sel2_valid", 64'(out_valid3), 64'd1);
        check("sel2_data", 64'(out_data3), 64'h0000_00B2);
        check("sel2_ch", 64'(out_ch3), 64'd2);
        in_valid3 = '0;

        // Random traffic
        for (int c = 0; c < 300; c++) begin
            drive(1'($urandom_range(0, 1)), SELW'($urandom_range(0, CH - 1)),
                  CH'($urandom_range(0, (1 << CH) - 1)), 1'($urandom_range(0, 3) != 0));
            for (int i = 0; i < CH; i++) in_data[i*WIDTH +: WIDTH] = $urandom;
            tick(1);
        end

        // Reset mid-stream with a full output register
        drive(1'b1, 2'd0, 4'hF, 1'b1);
        set_data_fixed();
        tick(2);
        check("pre_rst_valid", 64'(out_valid), 64'd1);
        #2;
        mon_en = 1'b0;
        rst_n  = 1'b0;
        #1;
        check("async_rst_valid", 64'(out_valid), 64'd0);
        check("async_rst_data", 64'(out_data), 64'd0);
        check("async_rst_ch", 64'(out_ch), 64'd0);
        check("async_rst_ptr", 64'(u_dut.ptr), 64'd0);
        check("async_rst_ready", 64'(in_ready), 64'd0);
        tick(2);
        check("held_rst_ready", 64'(in_ready), 64'd0);
        in_valid = '0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        tick(1);
        mon_en = 1'b1;
        drive(1'b1, 2'd0, 4'b0110, 1'b1);
        tick(5);
        drive(1'b1, 2'd0, 4'b0000, 1'b1);
        tick(2);
        mon_en = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
